sha256_msg_sched: RTL and testbench



---
 rtl/sha256_pkg.sv | 55 +++++
 rtl/func_msg_sigma.sv | 25 ++
 rtl/sha256_msg_sched.sv | 150 +++++++++++++++
 tb/tb_sha256_msg_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message schedule:
//   - word width and standard round count
//   - LOAD/EMIT state encoding of the schedule generator
//   - small sigma functions ssig0/ssig1 (also usable by a verification model)
//   - FIPS 180-4 round constant table K[0..63], present only when
//     SHA256_MSG_SCHED_KI_EN is defined
// -----------------------------------------------------------------------------
package sha256_pkg;

   localparam int WORD_W     = 32;
   localparam int ROUNDS_STD = 64;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_EMIT = 1'b1
   } sched_state_e;

   // ssig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0],  x[31:7]}  ^
             {x[17:0], x[31:18]} ^
             {3'b000,  x[31:3]};
   endfunction

   // ssig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^
             {x[18:0], x[31:19]} ^
             {10'b00_0000_0000, x[31:10]};
   endfunction

`ifdef SHA256_MSG_SCHED_KI_EN
   localparam logic [31:0] K_TABLE [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
`endif

endpackage : sha256_pkg

// File: rtl/func_msg_sigma.sv
// -----------------------------------------------------------------------------
// func_msg_sigma
// Combinational next-word function of the SHA-256 message schedule:
//   w_next = ssig1(w14) + w9 + ssig0(w1) + w0   (mod 2^32)
// where wN is the word N positions into the 16-word sliding window.
// Ports:
//   w0, w1, w9, w14 : input  32  window taps
//   w_next          : output 32  next schedule word
// -----------------------------------------------------------------------------
module func_msg_sigma
   import sha256_pkg::*;
(
   input  logic [31:0] w0,
   input  logic [31:0] w1,
   input  logic [31:0] w9,
   input  logic [31:0] w14,
   output logic [31:0] w_next
);

   // 32-bit sum; the carry out of bit 31 is intentionally dropped
   always_comb begin
      w_next = ssig1(w14) + w9 + ssig0(w1) + w0;
   end

endmodule : func_msg_sigma

// File: rtl/sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched
// SHA-256 message schedule generator. Loads one 512-bit block as 16 big-endian
// 32-bit words (M0 first) and then emits W0..W(ROUNDS-1) one per handshake,
// using a 16-word sliding window instead of a 64-word store.
//
// Parameters:
//   ROUNDS    : number of Wi emitted per block (16..64, 64 for SHA-256)
// Ports:
//   clk       : in   rising-edge clock
//   rst       : in   synchronous active-high reset
//   in_valid  : in   in_word valid
//   in_ready  : out  a message word is accepted this cycle (LOAD, not in reset)
//   in_word   : in   32-bit message word
//   out_valid : out  out_Wi/out_round valid (EMIT)
//   out_ready : in   consumer accepts Wi
//   out_Wi    : out  schedule word W_t (registered window head)
//   out_round : out  round index t (registered)
//   out_last  : out  high with out_valid on the final round
//   out_Ki    : out  K[out_round]; only when SHA256_MSG_SCHED_KI_EN is defined
//   busy      : out  high in EMIT
// Optional feature macro: SHA256_MSG_SCHED_KI_EN
// -----------------------------------------------------------------------------
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_Wi,
   output logic [5:0]  out_round,
   output logic        out_last,
`ifdef SHA256_MSG_SCHED_KI_EN
   output logic [31:0] out_Ki,
`endif
   output logic        busy
);

   localparam logic [5:0] RCNT_LAST = 6'(ROUNDS - 1);

   sched_state_e state_q, state_d;
   logic [3:0]   lcnt_q,  lcnt_d;
   logic [5:0]   rcnt_q,  rcnt_d;
   logic [31:0]  w_q [16];
   logic [31:0]  w_d [16];
   logic [31:0]  w_next;

   func_msg_sigma u_sigma (
      .w0     (w_q[0]),
      .w1     (w_q[1]),
      .w9     (w_q[9]),
      .w14    (w_q[14]),
      .w_next (w_next)
   );

   // State, counters and window registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
         lcnt_q  <= 4'd0;
         rcnt_q  <= 6'd0;
         for (int i = 0; i < 16; i++) begin
            w_q[i] <= 32'd0;
         end
      end else begin
         state_q <= state_d;
         lcnt_q  <= lcnt_d;
         rcnt_q  <= rcnt_d;
         for (int i = 0; i < 16; i++) begin
            w_q[i] <= w_d[i];
         end
      end
   end

   // Next-state logic: word capture in LOAD, window slide in EMIT
   always_comb begin
      state_d = state_q;
      lcnt_d  = lcnt_q;
      rcnt_d  = rcnt_q;
      for (int i = 0; i < 16; i++) begin
         w_d[i] = w_q[i];
      end

      case (state_q)
         ST_LOAD: begin
            // in_ready is unconditionally high in LOAD outside reset, and
            // reset overrides these values in the register process anyway
            if (in_valid) begin
               w_d[lcnt_q] = in_word;
               if (lcnt_q == 4'd15) begin
                  state_d = ST_EMIT;
                  lcnt_d  = 4'd0;
                  rcnt_d  = 6'd0;
               end else begin
                  lcnt_d  = lcnt_q + 4'd1;
               end
            end else begin
               lcnt_d = lcnt_q;
            end
         end
         ST_EMIT: begin
            // in_valid is ignored here; only the consumer handshake advances
            if (out_ready) begin
               for (int i = 0; i < 15; i++) begin
                  w_d[i] = w_q[i + 1];
               end
               w_d[15] = w_next;
               if (rcnt_q == RCNT_LAST) begin
                  state_d = ST_LOAD;
                  rcnt_d  = 6'd0;
               end else begin
                  rcnt_d  = rcnt_q + 6'd1;
               end
            end else begin
               rcnt_d = rcnt_q;
            end
         end
         default: begin
            state_d = ST_LOAD;
            lcnt_d  = 4'd0;
            rcnt_d  = 6'd0;
         end
      endcase
   end

   // Outputs derive only from registers, except in_ready which must drop
   // while rst is asserted
   always_comb begin
      in_ready  = (state_q == ST_LOAD) && !rst;
      out_valid = (state_q == ST_EMIT);
      busy      = (state_q == ST_EMIT);
      out_Wi    = w_q[0];
      out_round = rcnt_q;
      out_last  = (state_q == ST_EMIT) && (rcnt_q == RCNT_LAST);
   end

`ifdef SHA256_MSG_SCHED_KI_EN
   // Round constant aligned with out_round
   always_comb begin
      out_Ki = K_TABLE[out_round];
   end
`endif

endmodule : sha256_msg_sched

// File: tb/tb_sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_sched
// Self-checking bench for sha256_msg_sched. The reference model expands the
// block into the full 64-word FIPS 180-4 schedule array; known "abc" vectors
// are also checked from a constant table.
// -----------------------------------------------------------------------------
module tb_sha256_msg_sched;

   localparam int ROUNDS = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_Wi;
   logic [5:0]  out_round;
   logic        out_last;
   logic        busy;
`ifdef SHA256_MSG_SCHED_KI_EN
   logic [31:0] out_Ki;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] mblk [16];
   logic [31:0] wexp [64];
   logic [31:0] cap  [64];

   typedef struct {
      string       name;
      int          rnd;
      logic [31:0] wi;
   } vec_t;
   vec_t vecs [6];

   sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_Wi    (out_Wi),
      .out_round (out_round),
      .out_last  (out_last),
`ifdef SHA256_MSG_SCHED_KI_EN
      .out_Ki    (out_Ki),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] m_s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] m_s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Full-array schedule expansion straight from the FIPS recurrence
   task automatic build_model();
      for (int t = 0; t < 16; t++) wexp[t] = mblk[t];
      for (int t = 16; t < 64; t++)
         wexp[t] = m_s1(wexp[t-2]) + wexp[t-7] + m_s0(wexp[t-15]) + wexp[t-16];
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) mblk[i] = 32'h0;
      mblk[0]  = 32'h61626380;
      mblk[15] = 32'h00000018;
   endtask

   task automatic set_rand();
      for (int i = 0; i < 16; i++) mblk[i] = $urandom();
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      chk("in_ready_in_rst", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Feed 16 words of mblk; optional random in_valid gaps
   task automatic load_blk(input bit gaps);
      int n = 0;
      int guard = 0;
      while (n < 16 && guard < 500) begin
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_word  = in_valid ? mblk[n] : $urandom();
         #1;
         chk("in_ready_load", 32'(in_ready), 32'd1);
         chk("out_valid_load", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
         if (in_valid) n++;
         guard++;
      end
      in_valid = 1'b0;
      if (n < 16) begin
         total++; bad++;
         $display("FAIL load_timeout: got %0d words expected 16", n);
      end
   endtask

   // Consume rounds until stop_at handshakes; bp = random backpressure,
   // junk = in_valid held high with changing in_word
   task automatic emit(input int stop_at, input bit bp, input bit junk);
      int idx = 0;
      int guard = 0;
      while (idx < stop_at && guard < 2000) begin
         out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
         in_valid  = junk;
         in_word   = $urandom();
         #1;
         chk("out_valid", 32'(out_valid), 32'd1);
         chk("busy", 32'(busy), 32'd1);
         chk("in_ready_emit", 32'(in_ready), 32'd0);
         chk("out_Wi", out_Wi, wexp[idx]);
         chk("out_round", 32'(out_round), 32'(idx));
         chk("out_last", 32'(out_last), 32'(idx == ROUNDS - 1));
`ifdef SHA256_MSG_SCHED_KI_EN
         if (idx == 0)  chk("out_Ki_0", out_Ki, 32'h428A2F98);
         if (idx == 63) chk("out_Ki_63", out_Ki, 32'hC67178F2);
`endif
         cap[idx] = out_Wi;
         @(posedge clk); #1;
         if (out_ready) idx++;
         guard++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      if (idx < stop_at) begin
         total++; bad++;
         $display("FAIL emit_timeout: got %0d rounds expected %0d", idx, stop_at);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{"abc_W0",  0,  32'h61626380};
      vecs[1] = '{"abc_W15", 15, 32'h00000018};
      vecs[2] = '{"abc_W16", 16, 32'h61626380};
      vecs[3] = '{"abc_W17", 17, 32'h000F0000};
      vecs[4] = '{"abc_W18", 18, 32'h7DA86405};
      vecs[5] = '{"abc_W63", 63, 32'h12B1EDEB};

      rst = 1'b1; in_valid = 1'b0; in_word = 32'h0; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_in_rst", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_round", 32'(out_round), 32'd0);
      chk("rst_out_Wi", out_Wi, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // "abc" block, out_ready held high, then table check of known words
      set_abc(); build_model();
      load_blk(1'b0);
      emit(64, 1'b0, 1'b0);
      check_idle("abc_after");
      for (int i = 0; i < 6; i++) chk(vecs[i].name, cap[vecs[i].rnd], vecs[i].wi);

      // Backpressure plus in_valid junk during EMIT
      load_blk(1'b1);
      emit(64, 1'b1, 1'b1);
      check_idle("bp_after");

      // Reset at round 30 with a simultaneous handshake and in_valid
      load_blk(1'b0);
      emit(30, 1'b0, 1'b0);
      out_ready = 1'b1; in_valid = 1'b1;
      pulse_rst();
      out_ready = 1'b0; in_valid = 1'b0;
      #1;
      check_idle("rst_mid_emit");
      chk("rst_mid_emit_round", 32'(out_round), 32'd0);
      chk("rst_mid_emit_Wi", out_Wi, 32'd0);
      load_blk(1'b0);
      emit(64, 1'b0, 1'b0);
      check_idle("abc_reload_after");

      // Reset after a partial load discards the partial words
      set_rand();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_word = mblk[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      pulse_rst();
      in_valid = 1'b0;
      #1;
      check_idle("rst_mid_load");
      set_abc(); build_model();
      load_blk(1'b0);
      emit(64, 1'b0, 1'b0);

      // Back-to-back: zero block then "abc"
      for (int i = 0; i < 16; i++) mblk[i] = 32'h0;
      build_model();
      load_blk(1'b0);
      emit(64, 1'b0, 1'b0);
      set_abc(); build_model();
      load_blk(1'b0);
      emit(64, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) chk({vecs[i].name, "_b2b"}, cap[vecs[i].rnd], vecs[i].wi);

      // Random blocks with random gaps and backpressure
      for (int b = 0; b < 4; b++) begin
         set_rand(); build_model();
         load_blk(1'b1);
         emit(64, 1'b1, b[0]);
         check_idle("rand_after");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sha256_msg_sched
